// File: rtl/axi_b_alloc_pkg.sv
// axi_b_alloc_pkg
// Shared types and constants for the B-channel response allocator:
//   state_t       - allocator FSM states (IDLE / HOLD / ERR)
//   BRESP_*       - AXI write-response codes
package axi_b_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_b_err_fifo.sv
// axi_b_err_fifo
// Small synchronous FIFO holding pending decode-error responses ({id, user}).
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the queue)
//   push, din     - write request and data (ignored while full)
//   pop           - drop the head entry (ignored while empty)
//   head          - current head entry, valid while !empty
//   full, empty   - occupancy flags
// DEPTH must be a power of two so the pointers wrap for free.
module axi_b_err_fifo
    import axi_b_alloc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_b_resp_allocator.sv
// axi_b_resp_allocator
// Merges B responses from N_INIT_PORT sources onto one target B channel with a
// round-robin arbiter, injects queued DECERR responses for unmapped writes once
// no normal write is outstanding, and counts outstanding writes.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   bid_i/bresp_i/buser_i/bvalid_i    - per-source B channels (flattened)
//   bready_o                          - one-hot ready back to the granted source
//   bid_o/bresp_o/buser_o/bvalid_o    - merged B channel; bready_i from target
//   incr_req_i                        - a write was forwarded to a slave
//   full_counter_o/outstanding_trans_o- counter saturated / non-zero
//   error_req_i/error_gnt_o           - DECERR push handshake
//   error_id_i/error_user_i           - DECERR payload, sampled on push
//   err_count_o                       - issued DECERR count
// Optional feature: define AXI_B_ALLOC_ERR_STATS_EN to enable err_count_o;
// otherwise it is tied to zero.
module axi_b_resp_allocator
    import axi_b_alloc_pkg::*;
#(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_INIT_PORT),
    parameter int AXI_USER_W  = 6,
    parameter int CNT_W       = 10,
    parameter int ERR_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    output logic [AXI_ID_IN-1:0]              bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    input  logic                              incr_req_i,
    output logic                              full_counter_o,
    output logic                              outstanding_trans_o,
    input  logic                              error_req_i,
    output logic                              error_gnt_o,
    input  logic [AXI_ID_IN-1:0]              error_id_i,
    input  logic [AXI_USER_W-1:0]             error_user_i,
    output logic [15:0]                       err_count_o
);

    localparam int PTR_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
    localparam int ERR_W = AXI_ID_IN + AXI_USER_W;

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [PTR_W-1:0] lock, lock_next;
    logic [PTR_W-1:0] win, cand, sel;
    logic             win_found;
    logic             drive;
    logic             norm_hs;
    logic             pop;
    logic             push;
    logic             fifo_full, fifo_empty;
    logic [ERR_W-1:0] fifo_head;
    logic [CNT_W-1:0] cnt;

    // Only the low AXI_ID_IN bits of each source ID are forwarded.
    logic unused_bid;
    assign unused_bid = ^bid_i;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        int n;
        n = (int'(idx) + 1) % N_INIT_PORT;
        return PTR_W'(n);
    endfunction

    // Round-robin search starting at ptr, wrapping modulo N_INIT_PORT.
    always_comb begin
        win       = '0;
        cand      = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_INIT_PORT);
            if (!win_found && bvalid_i[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        lock_next  = lock;
        sel        = win;
        drive      = 1'b0;
        norm_hs    = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                // Pending DECERRs only go out once the target has no normal
                // response owed, so they never overtake a real one.
                if (!fifo_empty && cnt == '0) begin
                    state_next = ERR;
                end else if (win_found) begin
                    drive = 1'b1;
                    if (bready_i) begin
                        norm_hs  = 1'b1;
                        ptr_next = next_idx(win);
                    end else begin
                        state_next = HOLD;
                        lock_next  = win;
                    end
                end
            end
            HOLD: begin
                // Keep the offered beat stable until the target takes it.
                sel   = lock;
                drive = bvalid_i[lock];
                if (!bvalid_i[lock]) begin
                    state_next = IDLE;
                end else if (bready_i) begin
                    norm_hs    = 1'b1;
                    ptr_next   = next_idx(lock);
                    state_next = IDLE;
                end
            end
            ERR: begin
                if (bready_i) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bvalid_o = 1'b0;
        bready_o = '0;
        bid_o    = '0;
        bresp_o  = BRESP_OKAY;
        buser_o  = '0;
        if (!rst) begin
            if (state == ERR) begin
                bvalid_o         = 1'b1;
                bresp_o          = BRESP_DECERR;
                {bid_o, buser_o} = fifo_head;
            end else if (drive) begin
                bvalid_o      = 1'b1;
                bid_o         = bid_i[int'(sel)*AXI_ID_OUT +: AXI_ID_IN];
                bresp_o       = bresp_i[int'(sel)*2 +: 2];
                buser_o       = buser_i[int'(sel)*AXI_USER_W +: AXI_USER_W];
                bready_o[sel] = bready_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            lock  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            lock  <= lock_next;
        end
    end

    // Outstanding-write counter; simultaneous incr and decr cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (incr_req_i && !norm_hs && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end else if (!incr_req_i && norm_hs && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign full_counter_o      = (cnt == '1);
    assign outstanding_trans_o = (cnt != '0);

    assign error_gnt_o = !fifo_full && !rst;
    assign push        = error_req_i && error_gnt_o;

    axi_b_err_fifo #(
        .DEPTH (ERR_DEPTH),
        .WIDTH (ERR_W)
    ) u_err_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({error_id_i, error_user_i}),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef AXI_B_ALLOC_ERR_STATS_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (pop && err_cnt != '1) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign err_count_o = err_cnt;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_axi_b_resp_allocator.sv
module tb_axi_b_resp_allocator;

    localparam int N   = 4;
    localparam int IDI = 16;
    localparam int IDO = 18;
    localparam int UW  = 6;
    localparam int CW  = 10;
    localparam int ED  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*IDO-1:0]  bid_i;
    logic [N*2-1:0]    bresp_i;
    logic [N*UW-1:0]   buser_i;
    logic [N-1:0]      bvalid_i;
    logic [N-1:0]      bready_o;
    logic [IDI-1:0]    bid_o;
    logic [1:0]        bresp_o;
    logic [UW-1:0]     buser_o;
    logic              bvalid_o;
    logic              bready_i;
    logic              incr_req_i;
    logic              full_counter_o;
    logic              outstanding_trans_o;
    logic              error_req_i;
    logic              error_gnt_o;
    logic [IDI-1:0]    error_id_i;
    logic [UW-1:0]     error_user_i;
    logic [15:0]       err_count_o;

    axi_b_resp_allocator #(
        .N_INIT_PORT (N),
        .AXI_ID_IN   (IDI),
        .AXI_ID_OUT  (IDO),
        .AXI_USER_W  (UW),
        .CNT_W       (CW),
        .ERR_DEPTH   (ED)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bid_i               (bid_i),
        .bresp_i             (bresp_i),
        .buser_i             (buser_i),
        .bvalid_i            (bvalid_i),
        .bready_o            (bready_o),
        .bid_o               (bid_o),
        .bresp_o             (bresp_o),
        .buser_o             (buser_o),
        .bvalid_o            (bvalid_o),
        .bready_i            (bready_i),
        .incr_req_i          (incr_req_i),
        .full_counter_o      (full_counter_o),
        .outstanding_trans_o (outstanding_trans_o),
        .error_req_i         (error_req_i),
        .error_gnt_o         (error_gnt_o),
        .error_id_i          (error_id_i),
        .error_user_i        (error_user_i),
        .err_count_o         (err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDI-1:0] id;
        logic [1:0]     resp;
        logic [UW-1:0]  user;
    } beat_t;

    typedef struct {
        logic [N-1:0] valid;
        logic         ready;
        logic         exp_valid;
        int           exp_src;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[10];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [IDI-1:0] src_id(input int s);
        return 16'hA000 + 16'(s * 17);
    endfunction

    function automatic logic [1:0] src_resp(input int s);
        return (s % 2 == 1) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [UW-1:0] src_user(input int s);
        return UW'(s + 5);
    endfunction

    function automatic beat_t norm_beat(input int s);
        beat_t b;
        b.id   = src_id(s);
        b.resp = src_resp(s);
        b.user = src_user(s);
        return b;
    endfunction

    function automatic beat_t err_beat(input logic [IDI-1:0] id, input logic [UW-1:0] user);
        beat_t b;
        b.id   = id;
        b.resp = 2'b11;
        b.user = user;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare a completed B handshake against the scoreboard head.
    task automatic observe(input string tag);
        beat_t e;
        if (bvalid_o && bready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected: got beat id 0x%0h expected none", tag, bid_o);
            end else begin
                e = sb.pop_front();
                check({tag, "_id"},   bid_o,   e.id);
                check({tag, "_resp"}, bresp_o, e.resp);
                check({tag, "_user"}, buser_o, e.user);
            end
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bvalid_i    = '0;
        bready_i    = 1'b0;
        incr_req_i  = 1'b0;
        error_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        int got;
        int exp_ec;

        for (int s = 0; s < N; s++) begin
            bid_i[s*IDO +: IDO]  = {2'b11, src_id(s)};
            bresp_i[s*2 +: 2]    = src_resp(s);
            buser_i[s*UW +: UW]  = src_user(s);
        end
        error_id_i   = '0;
        error_user_i = '0;

        tbl[0] = '{4'b1111, 1'b1, 1'b1, 0};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 2};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 3};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 0};
        tbl[5] = '{4'b1010, 1'b1, 1'b1, 1};
        tbl[6] = '{4'b0011, 1'b1, 1'b1, 0};
        tbl[7] = '{4'b0101, 1'b1, 1'b1, 2};
        tbl[8] = '{4'b1001, 1'b1, 1'b1, 3};
        tbl[9] = '{4'b0000, 1'b1, 1'b0, 0};

        // Outputs held off during reset even with traffic pending.
        rst         = 1'b1;
        bvalid_i    = 4'b1111;
        bready_i    = 1'b1;
        incr_req_i  = 1'b0;
        error_req_i = 1'b1;
        #1;
        check("rst_bvalid", bvalid_o, 0);
        check("rst_bready", bready_o, 0);
        check("rst_gnt", error_gnt_o, 0);
        check("rst_bid", bid_o, 0);
        do_reset();
        #1;
        check("post_rst_full", full_counter_o, 0);
        check("post_rst_outst", outstanding_trans_o, 0);
        check("post_rst_errcnt", err_count_o, 0);

        // Round-robin vectors.
        for (int i = 0; i < 10; i++) begin
            bvalid_i = tbl[i].valid;
            bready_i = tbl[i].ready;
            if (tbl[i].exp_valid && tbl[i].ready) sb.push_back(norm_beat(tbl[i].exp_src));
            #1;
            check($sformatf("rr%0d_bvalid", i), bvalid_o, tbl[i].exp_valid);
            check($sformatf("rr%0d_bready", i), bready_o,
                  (tbl[i].exp_valid && tbl[i].ready) ? 64'(1 << tbl[i].exp_src) : 64'd0);
            observe($sformatf("rr%0d", i));
            tick();
        end
        bvalid_i = '0;
        #1;
        check("cnt_floor", outstanding_trans_o, 0);

        // Grant lock while target stalls.
        do_reset();
        bvalid_i = 4'b0100;
        bready_i = 1'b0;
        sb.push_back(norm_beat(2));
        #1;
        check("lock_bvalid", bvalid_o, 1);
        check("lock_bid0", bid_o, src_id(2));
        check("lock_bready0", bready_o, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            bvalid_i = 4'b0101;
            #1;
            check($sformatf("lock_bid_hold%0d", c), bid_o, src_id(2));
            check($sformatf("lock_bready_hold%0d", c), bready_o, 0);
            tick();
        end
        bready_i = 1'b1;
        #1;
        check("lock_bready_hs", bready_o, 4'b0100);
        observe("lock_hs");
        tick();
        bvalid_i = 4'b0001;
        sb.push_back(norm_beat(0));
        #1;
        check("lock_next_bready", bready_o, 4'b0001);
        observe("lock_next");
        tick();
        bvalid_i = '0;

        // DECERR waits for outstanding writes to drain.
        do_reset();
        incr_req_i = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        incr_req_i = 1'b0;
        #1;
        check("outst_3", outstanding_trans_o, 1);
        error_req_i  = 1'b1;
        error_id_i   = 16'h0012;
        error_user_i = 6'h2A;
        #1;
        check("err_push_gnt", error_gnt_o, 1);
        tick();
        error_req_i = 1'b0;
        bready_i    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("no_early_decerr%0d", c), bvalid_o, 0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            bvalid_i = 4'b0010;
            sb.push_back(norm_beat(1));
            #1;
            check($sformatf("drain_bvalid%0d", c), bvalid_o, 1);
            observe($sformatf("drain%0d", c));
            tick();
        end
        bvalid_i = '0;
        #1;
        check("err_gap", bvalid_o, 0);
        tick();
        sb.push_back(err_beat(16'h0012, 6'h2A));
        #1;
        check("err_bvalid", bvalid_o, 1);
        check("err_bready", bready_o, 0);
        observe("err");
        check("err_outst", outstanding_trans_o, 0);
        tick();
        #1;
        check("err_done", bvalid_o, 0);

        // Queue overflow and FIFO-order drain.
        do_reset();
        bready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            error_req_i  = 1'b1;
            error_id_i   = 16'h0021 + 16'(k);
            error_user_i = UW'(k);
            #1;
            check($sformatf("q_gnt%0d", k), error_gnt_o, (k < 4) ? 1 : 0);
            if (k < 4) sb.push_back(err_beat(16'h0021 + 16'(k), UW'(k)));
            tick();
        end
        error_req_i = 1'b0;
        bready_i    = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #1;
            check($sformatf("q_bready%0d", c), bready_o, 0);
            if (bvalid_o) got++;
            observe($sformatf("q%0d", c));
            tick();
        end
        check("q_drain_count", got, 4);
        check("q_sb_empty", sb.size(), 0);
`ifdef AXI_B_ALLOC_ERR_STATS_EN
        exp_ec = 4;
`else
        exp_ec = 0;
`endif
        check("q_err_count", err_count_o, exp_ec);
        bready_i = 1'b0;

        // Counter saturation and cancel.
        do_reset();
        incr_req_i = 1'b1;
        for (int c = 0; c < 1023; c++) tick();
        #1;
        check("sat_full", full_counter_o, 1);
        tick();
        #1;
        check("sat_hold", full_counter_o, 1);
        incr_req_i = 1'b0;
        bvalid_i   = 4'b0001;
        bready_i   = 1'b1;
        sb.push_back(norm_beat(0));
        #1;
        observe("sat_dec");
        tick();
        bvalid_i = '0;
        #1;
        check("sat_dec_full", full_counter_o, 0);
        incr_req_i = 1'b1;
        bvalid_i   = 4'b0001;
        sb.push_back(norm_beat(0));
        #1;
        observe("sat_both");
        tick();
        incr_req_i = 1'b0;
        bvalid_i   = '0;
        #1;
        check("sat_both_full", full_counter_o, 0);
        incr_req_i = 1'b1;
        tick();
        incr_req_i = 1'b0;
        #1;
        check("sat_refill", full_counter_o, 1);

        // Reset while presenting a DECERR.
        do_reset();
        bready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            error_req_i  = 1'b1;
            error_id_i   = 16'h0031 + 16'(k);
            error_user_i = 6'h11;
            tick();
        end
        error_req_i = 1'b0;
        #1;
        check("rerr_in_err", bvalid_o, 1);
        rst         = 1'b1;
        error_req_i = 1'b1;
        bready_i    = 1'b1;
        #1;
        check("rerr_rst_bvalid", bvalid_o, 0);
        check("rerr_rst_bready", bready_o, 0);
        check("rerr_rst_gnt", error_gnt_o, 0);
        tick();
        rst         = 1'b0;
        error_req_i = 1'b0;
        #1;
        check("rerr_bvalid", bvalid_o, 0);
        check("rerr_outst", outstanding_trans_o, 0);
        check("rerr_gnt", error_gnt_o, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check($sformatf("rerr_empty%0d", c), bvalid_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
